// File: rtl/dmem_lsu.sv
// Data memory with valid/ready load/store front end, registered read path and
// programmable wait states. Define DMEM_LSU_MISALIGN_ERR_EN to fault misaligned accesses.
module dmem_lsu #(
  parameter int MEM_DEPTH = 1024,
  parameter int ADDR_W    = 32,
  parameter int LATENCY   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  // state  | meaning
  // S_IDLE | ready for a request; accept latches check result, load data, commits store
  // S_WAIT | r_cnt counts the read-register cycle plus LATENCY wait cycles
  // S_RESP | response held stable until rsp_ready
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int              IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W:0] BYTE_CAP = (ADDR_W+1)'(MEM_DEPTH) << 2;
  localparam logic [3:0]      LAT_CNT  = 4'(LATENCY);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;
  logic [31:0] r_mem [MEM_DEPTH];

  logic             w_accept;
  logic             w_range_err;
  logic             w_size_err;
  logic             w_align_err;
  logic             w_err;
  logic [1:0]       w_lane;
  logic [IDX_W-1:0] w_idx;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata_sh;
  logic [31:0]      w_rword;
  logic [31:0]      w_word_sh;
  logic [31:0]      w_ldata;

  assign w_accept    = rst_n && r_req_ready && req_valid;
  assign w_range_err = {1'b0, req_addr} >= BYTE_CAP;
  assign w_size_err  = (req_size == 2'd3);
  assign w_idx       = req_addr[IDX_W+1:2];

`ifdef DMEM_LSU_MISALIGN_ERR_EN
  assign w_align_err = ((req_size == 2'd1) && req_addr[0]) ||
                       ((req_size == 2'd2) && (req_addr[1:0] != 2'd0));
  assign w_lane      = req_addr[1:0];
`else
  assign w_align_err = 1'b0;
  always_comb begin
    w_lane = req_addr[1:0];
    if (req_size == 2'd1) w_lane[0] = 1'b0;
    if (req_size == 2'd2) w_lane    = 2'd0;
  end
`endif

  assign w_err = w_range_err || w_size_err || w_align_err;

  always_comb begin
    w_be       = 4'b0000;
    w_wdata_sh = req_wdata;
    case (req_size)
      2'd0: begin
        w_be       = 4'b0001 << w_lane;
        w_wdata_sh = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        w_be       = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata_sh = {2{req_wdata[15:0]}};
      end
      2'd2:    w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  assign w_rword   = r_mem[w_idx];
  assign w_word_sh = w_rword >> {w_lane, 3'b000};

  always_comb begin
    case (req_size)
      2'd0:    w_ldata = req_unsigned ? {24'd0, w_word_sh[7:0]}
                                      : {{24{w_word_sh[7]}}, w_word_sh[7:0]};
      2'd1:    w_ldata = req_unsigned ? {16'd0, w_word_sh[15:0]}
                                      : {{16{w_word_sh[15]}}, w_word_sh[15:0]};
      default: w_ldata = w_rword;
    endcase
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (w_accept && req_write && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (req_write || w_err) ? 32'd0 : w_ldata;
            r_cnt       <= LAT_CNT;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: directed requests push expected responses,
// a negedge monitor pops and compares them, and also checks response latency.
module tb_dmem_lsu;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_ready = 1'b1;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  int vec = 0;
  int miscmp = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit in_rsp = 1'b0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;
  exp_t q[$];
  exp_t m_e;

  dmem_lsu #(.MEM_DEPTH(1024), .ADDR_W(32), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (!in_rsp) begin
        in_rsp = 1'b1;
        chk("latency", 32'(cyc - acc_cyc), 32'(LAT + 1));
      end
      if (rsp_ready) begin
        in_rsp = 1'b0;
        if (q.size() == 0) begin
          vec++;
          miscmp++;
          $display("FAIL unexpected_rsp: got rdata %h err %b with nothing outstanding", rsp_rdata, rsp_err);
        end else begin
          m_e = q.pop_front();
          chk({m_e.name, "_rdata"}, rsp_rdata, m_e.rdata);
          chk({m_e.name, "_err"}, 32'(rsp_err), 32'(m_e.err));
        end
      end
    end
  end

  task automatic issue(input string nm, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      vec++; miscmp++;
      $display("FAIL %s_accept: req_ready got 0 expected 1 within 50 cycles", nm);
      req_valid = 1'b0;
      return;
    end
    q.push_back('{rdata: er, err: ee, name: nm});
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (q.size() != 0) begin
      vec++; miscmp++;
      $display("FAIL %s_timeout: response missing after 100 cycles, expected one", nm);
      q.delete();
    end
  endtask

  task automatic do_req(input string nm, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee);
    issue(nm, wr, sz, uns, a, wd, er, ee);
    wait_done(nm);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_rsp_rdata", rsp_rdata,      32'd0);

    // word store/load
    do_req("st_w10", 1, 2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    do_req("ld_w10", 0, 2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);

    // byte lane and sign/zero extension
    do_req("st_w20", 1, 2, 0, 32'h20, 32'h11223344, 32'h0, 0);
    do_req("st_b21", 1, 0, 0, 32'h21, 32'hFFFFFF80, 32'h0, 0);
    do_req("ld_bs21", 0, 0, 0, 32'h21, 32'h0, 32'hFFFFFF80, 0);
    do_req("ld_bu21", 0, 0, 1, 32'h21, 32'h0, 32'h00000080, 0);
    do_req("ld_w20", 0, 2, 0, 32'h20, 32'h0, 32'h11228044, 0);

    // halfword lanes
    do_req("st_w30", 1, 2, 0, 32'h30, 32'hAABBCCDD, 32'h0, 0);
    do_req("st_h32", 1, 1, 0, 32'h32, 32'hFFFF1234, 32'h0, 0);
    do_req("ld_w30", 0, 2, 0, 32'h30, 32'h0, 32'h1234CCDD, 0);
    do_req("ld_hs32", 0, 1, 0, 32'h32, 32'h0, 32'h00001234, 0);
    do_req("ld_hs30", 0, 1, 0, 32'h30, 32'h0, 32'hFFFFCCDD, 0);
    do_req("ld_hu30", 0, 1, 1, 32'h30, 32'h0, 32'h0000CCDD, 0);
    do_req("ld_bs33", 0, 0, 0, 32'h33, 32'h0, 32'h00000012, 0);

    // range boundary: 0xFFC is last word, 0x1000 faults and must not alias word 0
    do_req("st_w0", 1, 2, 0, 32'h0, 32'h01020304, 32'h0, 0);
    do_req("st_wffc", 1, 2, 0, 32'hFFC, 32'hCAFEF00D, 32'h0, 0);
    do_req("ld_wffc", 0, 2, 0, 32'hFFC, 32'h0, 32'hCAFEF00D, 0);
    do_req("ld_w1000", 0, 2, 0, 32'h1000, 32'h0, 32'h0, 1);
    do_req("st_w1000", 1, 2, 0, 32'h1000, 32'h99999999, 32'h0, 1);
    do_req("ld_w0_after", 0, 2, 0, 32'h0, 32'h0, 32'h01020304, 0);
    do_req("ld_hi_addr", 0, 0, 0, 32'h8000_0010, 32'h0, 32'h0, 1);

    // illegal size
    do_req("ld_sz3", 0, 3, 0, 32'h10, 32'h0, 32'h0, 1);
    do_req("st_sz3", 1, 3, 0, 32'h10, 32'h0, 32'h0, 1);
    do_req("ld_w10_after", 0, 2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);

    // misalignment
    do_req("st_w40", 1, 2, 0, 32'h40, 32'h55667788, 32'h0, 0);
`ifdef DMEM_LSU_MISALIGN_ERR_EN
    do_req("ld_w42", 0, 2, 0, 32'h42, 32'h0, 32'h0, 1);
    do_req("st_h41", 1, 1, 0, 32'h41, 32'h0000ABCD, 32'h0, 1);
    do_req("ld_w40", 0, 2, 0, 32'h40, 32'h0, 32'h55667788, 0);
`else
    do_req("ld_w42", 0, 2, 0, 32'h42, 32'h0, 32'h55667788, 0);
    do_req("st_h41", 1, 1, 0, 32'h41, 32'h0000ABCD, 32'h0, 0);
    do_req("ld_w40", 0, 2, 0, 32'h40, 32'h0, 32'h5566ABCD, 0);
`endif

    // backpressure: response must hold while rsp_ready is low
    rsp_ready = 1'b0;
    issue("hold", 0, 2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("hold_err", 32'(rsp_err), 32'd0);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_done("hold");

    // reset in WAIT drops the response but keeps the committed store
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h50; req_wdata = 32'h0BADF00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    do_req("ld_w50", 0, 2, 0, 32'h50, 32'h0, 32'h0BADF00D, 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
